// File: rtl/mc_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_pkg
// Description : Shared state, class and datapath-select encodings for the
//               multi-cycle MIPS control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_control_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_MUL_WAIT = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_ADDR     = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_MEM_WR   = 4'd7,
        ST_WB_R     = 4'd8,
        ST_WB_I     = 4'd9,
        ST_WB_MEM   = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_TRAP     = 4'd13
    } state_t;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_MUL     = 3'd1,
        CLS_ADDI    = 3'd2,
        CLS_LOAD    = 3'd3,
        CLS_STORE   = 3'd4,
        CLS_BRANCH  = 3'd5,
        CLS_JUMP    = 3'd6,
        CLS_ILLEGAL = 3'd7
    } iclass_t;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_mul   = 6'h1c;
    localparam logic [5:0] c_op_lb    = 6'h20;
    localparam logic [5:0] c_op_lh    = 6'h21;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_lbu   = 6'h24;
    localparam logic [5:0] c_op_lhu   = 6'h25;
    localparam logic [5:0] c_op_sb    = 6'h28;
    localparam logic [5:0] c_op_sh    = 6'h29;
    localparam logic [5:0] c_op_sw    = 6'h2b;

    localparam logic [1:0] c_pc_src_seq    = 2'b00;
    localparam logic [1:0] c_pc_src_branch = 2'b01;
    localparam logic [1:0] c_pc_src_jump   = 2'b10;

    localparam logic [1:0] c_alub_rt      = 2'b00;
    localparam logic [1:0] c_alub_four    = 2'b01;
    localparam logic [1:0] c_alub_imm     = 2'b10;
    localparam logic [1:0] c_alub_imm_sh2 = 2'b11;

    localparam logic [1:0] c_alu_add   = 2'b00;
    localparam logic [1:0] c_alu_sub   = 2'b01;
    localparam logic [1:0] c_alu_funct = 2'b10;

    localparam logic [1:0] c_size_byte = 2'b00;
    localparam logic [1:0] c_size_half = 2'b01;
    localparam logic [1:0] c_size_word = 2'b10;

    // Access width is carried in the low two opcode bits of every load/store.
    function automatic logic [1:0] mem_size_of(input logic [1:0] sel);
        case (sel)
            2'b11:   return c_size_word;
            2'b01:   return c_size_half;
            default: return c_size_byte;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_opcode_decode.sv
`default_nettype none
// ============================================================================
// Module      : mc_opcode_decode
// Description : Combinational opcode classifier for the multi-cycle control.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_opcode_decode
    import mc_control_pkg::*;
#(
    parameter bit ENABLE_MUL = 1'b1
) (
    input  logic [5:0] i_opcode,
    output iclass_t    o_iclass,
    output logic [1:0] o_mem_size,
    output logic       o_mem_unsigned,
    output logic       o_legal,
    output logic       o_is_bne
);

    logic w_is_mem;

    always_comb begin
        o_iclass = CLS_ILLEGAL;
        o_is_bne = 1'b0;
        case (i_opcode)
            c_op_rtype: o_iclass = CLS_R;
            c_op_mul:   o_iclass = ENABLE_MUL ? CLS_MUL : CLS_ILLEGAL;
            c_op_addi:  o_iclass = CLS_ADDI;
            c_op_lb, c_op_lh, c_op_lw, c_op_lbu, c_op_lhu:
                        o_iclass = CLS_LOAD;
            c_op_sb, c_op_sh, c_op_sw:
                        o_iclass = CLS_STORE;
            c_op_beq:   o_iclass = CLS_BRANCH;
            c_op_bne: begin
                o_iclass = CLS_BRANCH;
                o_is_bne = 1'b1;
            end
            c_op_j:     o_iclass = CLS_JUMP;
            default:    o_iclass = CLS_ILLEGAL;
        endcase
    end

    assign w_is_mem       = (o_iclass == CLS_LOAD) || (o_iclass == CLS_STORE);
    assign o_legal        = (o_iclass != CLS_ILLEGAL);
    assign o_mem_size     = w_is_mem ? mem_size_of(i_opcode[1:0]) : c_size_byte;
    assign o_mem_unsigned = w_is_mem & i_opcode[2];

endmodule
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_fsm
// Description : Multi-cycle MIPS main control sequencer with memory
//               handshakes, multi-cycle multiply and illegal-opcode trap.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_control_fsm
    import mc_control_pkg::*;
#(
    parameter int unsigned MUL_LATENCY     = 4,
    parameter bit          ENABLE_MUL      = 1'b1,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic [1:0] mem_size,
    output logic       mem_unsigned,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       mul_start,
    output logic       retire,
    output logic       illegal_op
);

    localparam logic [3:0] c_mul_init = 4'(MUL_LATENCY - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_mul_cnt;
    iclass_t    r_class;
    logic [1:0] r_mem_size;
    logic       r_mem_unsigned;
    logic       r_is_bne;

    iclass_t    w_class;
    logic [1:0] w_dec_size;
    logic       w_dec_unsigned;
    logic       w_legal;
    logic       w_is_bne;

    mc_opcode_decode #(
        .ENABLE_MUL (ENABLE_MUL)
    ) u_decode (
        .i_opcode       (opcode),
        .o_iclass       (w_class),
        .o_mem_size     (w_dec_size),
        .o_mem_unsigned (w_dec_unsigned),
        .o_legal        (w_legal),
        .o_is_bne       (w_is_bne)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_FETCH;
            r_mul_cnt      <= 4'd0;
            r_class        <= CLS_R;
            r_mem_size     <= c_size_byte;
            r_mem_unsigned <= 1'b0;
            r_is_bne       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // The IR is only guaranteed stable from DECODE, so capture the
            // decoded attributes there and run the rest of the flow from them.
            if (r_state == ST_DECODE) begin
                r_class        <= w_class;
                r_mem_size     <= w_dec_size;
                r_mem_unsigned <= w_dec_unsigned;
                r_is_bne       <= w_is_bne;
                r_mul_cnt      <= c_mul_init;
            end else if ((r_state == ST_MUL_WAIT) && (r_mul_cnt != 4'd0)) begin
                r_mul_cnt <= r_mul_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        imem_req     = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = c_pc_src_seq;
        alu_src_b    = c_alub_rt;
        alu_op       = c_alu_add;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        mem_size     = c_size_byte;
        mem_unsigned = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        mul_start    = 1'b0;
        retire       = 1'b0;
        illegal_op   = 1'b0;

        if (!rst) begin
            case (r_state)
                ST_FETCH: begin
                    imem_req  = 1'b1;
                    alu_src_b = c_alub_four;
                    alu_op    = c_alu_add;
                    if (imem_ready) begin
                        ir_write     = 1'b1;
                        pc_write     = 1'b1;
                        pc_src       = c_pc_src_seq;
                        w_next_state = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    alu_src_b = c_alub_imm_sh2;
                    if (!w_legal) begin
                        if (HALT_ON_ILLEGAL) begin
                            w_next_state = ST_TRAP;
                        end else begin
                            retire       = 1'b1;
                            w_next_state = ST_FETCH;
                        end
                    end else begin
                        case (w_class)
                            CLS_R:                w_next_state = ST_EXEC_R;
                            CLS_MUL:              w_next_state = ST_MUL_WAIT;
                            CLS_ADDI:             w_next_state = ST_EXEC_I;
                            CLS_LOAD, CLS_STORE:  w_next_state = ST_ADDR;
                            CLS_BRANCH:           w_next_state = ST_BRANCH;
                            CLS_JUMP:             w_next_state = ST_JUMP;
                            default:              w_next_state = ST_TRAP;
                        endcase
                    end
                end
                ST_EXEC_R: begin
                    alu_op       = c_alu_funct;
                    alu_src_b    = c_alub_rt;
                    w_next_state = ST_WB_R;
                end
                ST_MUL_WAIT: begin
                    mul_start = (r_mul_cnt == c_mul_init);
                    if (r_mul_cnt == 4'd0) begin
                        w_next_state = ST_WB_R;
                    end
                end
                ST_EXEC_I: begin
                    alu_op       = c_alu_add;
                    alu_src_b    = c_alub_imm;
                    w_next_state = ST_WB_I;
                end
                ST_ADDR: begin
                    alu_op       = c_alu_add;
                    alu_src_b    = c_alub_imm;
                    mem_size     = r_mem_size;
                    mem_unsigned = r_mem_unsigned;
                    w_next_state = (r_class == CLS_LOAD) ? ST_MEM_RD : ST_MEM_WR;
                end
                ST_MEM_RD: begin
                    dmem_req     = 1'b1;
                    mem_size     = r_mem_size;
                    mem_unsigned = r_mem_unsigned;
                    if (dmem_ready) begin
                        w_next_state = ST_WB_MEM;
                    end
                end
                ST_MEM_WR: begin
                    dmem_req     = 1'b1;
                    dmem_we      = 1'b1;
                    mem_size     = r_mem_size;
                    mem_unsigned = r_mem_unsigned;
                    if (dmem_ready) begin
                        retire       = 1'b1;
                        w_next_state = ST_FETCH;
                    end
                end
                ST_WB_R: begin
                    reg_write    = 1'b1;
                    reg_dst      = 1'b1;
                    retire       = 1'b1;
                    w_next_state = ST_FETCH;
                end
                ST_WB_I: begin
                    reg_write    = 1'b1;
                    retire       = 1'b1;
                    w_next_state = ST_FETCH;
                end
                ST_WB_MEM: begin
                    reg_write    = 1'b1;
                    mem_to_reg   = 1'b1;
                    mem_size     = r_mem_size;
                    mem_unsigned = r_mem_unsigned;
                    retire       = 1'b1;
                    w_next_state = ST_FETCH;
                end
                ST_BRANCH: begin
                    alu_op       = c_alu_sub;
                    alu_src_b    = c_alub_rt;
                    pc_src       = c_pc_src_branch;
                    pc_write     = zero ^ r_is_bne;
                    retire       = 1'b1;
                    w_next_state = ST_FETCH;
                end
                ST_JUMP: begin
                    pc_write     = 1'b1;
                    pc_src       = c_pc_src_jump;
                    retire       = 1'b1;
                    w_next_state = ST_FETCH;
                end
                ST_TRAP: begin
                    illegal_op = 1'b1;
                end
                default: begin
                    w_next_state = ST_FETCH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_control_fsm
// Description : Self-checking bench for mc_control_fsm across three configs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control_fsm;

    typedef struct packed {
        logic       imem_req;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       dmem_req;
        logic       dmem_we;
        logic [1:0] mem_size;
        logic       mem_unsigned;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       mul_start;
        logic       retire;
        logic       illegal_op;
    } obs_t;

    localparam int K_R = 0, K_MUL = 1, K_ADDI = 2, K_LD = 3, K_ST = 4, K_BR = 5, K_J = 6, K_ILL = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       zero = 1'b0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;
    logic [5:0] opcode = 6'd0;
    obs_t       o0, o1, o2;

    int lat_of [3] = '{4, 4, 2};
    bit en_of  [3] = '{1'b1, 1'b0, 1'b1};
    bit halt_of[3] = '{1'b1, 1'b1, 1'b0};

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mc_control_fsm #(.MUL_LATENCY(4), .ENABLE_MUL(1'b1), .HALT_ON_ILLEGAL(1'b1)) dut0 (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(o0.imem_req), .ir_write(o0.ir_write), .pc_write(o0.pc_write), .pc_src(o0.pc_src),
        .alu_src_b(o0.alu_src_b), .alu_op(o0.alu_op), .dmem_req(o0.dmem_req), .dmem_we(o0.dmem_we),
        .mem_size(o0.mem_size), .mem_unsigned(o0.mem_unsigned), .reg_write(o0.reg_write), .reg_dst(o0.reg_dst),
        .mem_to_reg(o0.mem_to_reg), .mul_start(o0.mul_start), .retire(o0.retire), .illegal_op(o0.illegal_op));

    mc_control_fsm #(.MUL_LATENCY(4), .ENABLE_MUL(1'b0), .HALT_ON_ILLEGAL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(o1.imem_req), .ir_write(o1.ir_write), .pc_write(o1.pc_write), .pc_src(o1.pc_src),
        .alu_src_b(o1.alu_src_b), .alu_op(o1.alu_op), .dmem_req(o1.dmem_req), .dmem_we(o1.dmem_we),
        .mem_size(o1.mem_size), .mem_unsigned(o1.mem_unsigned), .reg_write(o1.reg_write), .reg_dst(o1.reg_dst),
        .mem_to_reg(o1.mem_to_reg), .mul_start(o1.mul_start), .retire(o1.retire), .illegal_op(o1.illegal_op));

    mc_control_fsm #(.MUL_LATENCY(2), .ENABLE_MUL(1'b1), .HALT_ON_ILLEGAL(1'b0)) dut2 (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(o2.imem_req), .ir_write(o2.ir_write), .pc_write(o2.pc_write), .pc_src(o2.pc_src),
        .alu_src_b(o2.alu_src_b), .alu_op(o2.alu_op), .dmem_req(o2.dmem_req), .dmem_we(o2.dmem_we),
        .mem_size(o2.mem_size), .mem_unsigned(o2.mem_unsigned), .reg_write(o2.reg_write), .reg_dst(o2.reg_dst),
        .mem_to_reg(o2.mem_to_reg), .mul_start(o2.mul_start), .retire(o2.retire), .illegal_op(o2.illegal_op));

    function automatic obs_t pick(input int sel);
        case (sel)
            0:       return o0;
            1:       return o1;
            default: return o2;
        endcase
    endfunction

    function automatic int kind_of(input logic [5:0] op, input bit en_mul);
        case (op)
            6'h00:                             return K_R;
            6'h1c:                             return en_mul ? K_MUL : K_ILL;
            6'h08:                             return K_ADDI;
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: return K_LD;
            6'h28, 6'h29, 6'h2b:               return K_ST;
            6'h04, 6'h05:                      return K_BR;
            6'h02:                             return K_J;
            default:                           return K_ILL;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit im, input bit dr, input bit z, input logic [5:0] op);
        @(negedge clk);
        rst        = r;
        imem_ready = im;
        dmem_ready = dr;
        zero       = z;
        opcode     = op;
        #1;
    endtask

    task automatic do_reset(input int sel);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 6'($urandom));
            check($sformatf("dut%0d_reset_outputs_zero", sel), {12'd0, pick(sel)}, 32'd0);
        end
    endtask

    // One instruction from reset: fi fetch stall cycles, dm data-memory stall cycles.
    task automatic run_instr(input int sel, input logic [5:0] op, input int fi, input int dm, input bit z);
        obs_t       o;
        obs_t       e;
        int         k, ret, w, exp_pcw, exp_size;
        bit         trap, is_mem, exp_regw;
        int         n_ret, first_ret, n_regw, regw_cyc, n_mul, mul_cyc, n_pcw, n_irw;
        int         n_dmreq, n_dmwe, size_seen, n_imreq_late, n_illeg;
        logic       regw_dst, regw_m2r, uns_seen;
        logic [1:0] lo;
        string      t;

        t        = $sformatf("dut%0d_op%02h", sel, op);
        k        = kind_of(op, en_of[sel]);
        trap     = (k == K_ILL) && halt_of[sel];
        is_mem   = (k == K_LD) || (k == K_ST);
        exp_regw = (k == K_R) || (k == K_MUL) || (k == K_ADDI) || (k == K_LD);
        lo       = op[1:0];
        exp_size = (lo == 2'b11) ? 2 : (lo == 2'b01) ? 1 : 0;
        case (k)
            K_R, K_ADDI: ret = fi + 4;
            K_MUL:       ret = fi + 3 + lat_of[sel];
            K_LD:        ret = fi + 5 + dm;
            K_ST:        ret = fi + 4 + dm;
            K_BR, K_J:   ret = fi + 3;
            default:     ret = trap ? -1 : fi + 2;
        endcase
        w       = trap ? fi + 23 : ret;
        exp_pcw = 1 + ((k == K_J) ? 1 : (k == K_BR) ? int'(z ^ op[0]) : 0);

        n_ret = 0; first_ret = -1; n_regw = 0; regw_cyc = -1; n_mul = 0; mul_cyc = -1;
        n_pcw = 0; n_irw = 0; n_dmreq = 0; n_dmwe = 0; size_seen = -1; n_imreq_late = 0; n_illeg = 0;
        regw_dst = 1'b0; regw_m2r = 1'b0; uns_seen = 1'b0;

        do_reset(sel);
        for (int c = 1; c <= w; c++) begin
            step(1'b0, c > fi, c >= fi + 4 + dm, z, (c <= fi + 1) ? 6'($urandom) : op);
            o = pick(sel);
            if (c == 1) check({t, "_fetch_req"}, 32'(o.imem_req), 32'd1);
            if (c == fi + 1)
                check({t, "_fetch_done"}, {25'd0, o.ir_write, o.pc_write, o.pc_src, o.alu_src_b, o.alu_op} >> 2,
                      32'b1_1_00_01);
            if (c == fi + 2) check({t, "_decode_alub"}, {29'd0, o.imem_req, o.alu_src_b}, 32'b0_11);
            if (c == fi + 3) begin
                case (k)
                    K_R:              check({t, "_exec_sel"}, {26'd0, o.alu_op, o.alu_src_b, o.pc_src}, 32'b10_00_00);
                    K_ADDI, K_LD, K_ST: check({t, "_exec_sel"}, {26'd0, o.alu_op, o.alu_src_b, o.pc_src}, 32'b00_10_00);
                    K_BR:             check({t, "_exec_sel"}, {26'd0, o.alu_op, o.alu_src_b, o.pc_src}, 32'b01_00_01);
                    K_J:              check({t, "_exec_sel"}, {30'd0, o.pc_src}, 32'b10);
                    K_MUL:            check({t, "_mul_first"}, 32'(o.mul_start), 32'd1);
                    default: begin
                        e = '0;
                        e.illegal_op = 1'b1;
                        check({t, "_trap_outputs"}, {12'd0, o}, {12'd0, e});
                    end
                endcase
            end
            if (o.retire) begin
                n_ret++;
                if (first_ret < 0) first_ret = c;
            end
            if (o.reg_write) begin
                n_regw++;
                regw_cyc = c;
                regw_dst = o.reg_dst;
                regw_m2r = o.mem_to_reg;
            end
            if (o.mul_start) begin
                n_mul++;
                mul_cyc = c;
            end
            if (o.pc_write) n_pcw++;
            if (o.ir_write) n_irw++;
            if (o.dmem_req) begin
                n_dmreq++;
                if (size_seen < 0) begin
                    size_seen = int'(o.mem_size);
                    uns_seen  = o.mem_unsigned;
                end
            end
            if (o.dmem_we) n_dmwe++;
            if (c >= fi + 2 && o.imem_req) n_imreq_late++;
            if (o.illegal_op) n_illeg++;
        end

        check({t, "_retire_count"}, 32'(n_ret), trap ? 32'd0 : 32'd1);
        if (!trap) check({t, "_retire_cycle"}, 32'(first_ret), 32'(ret));
        check({t, "_regwrite_count"}, 32'(n_regw), 32'(exp_regw));
        if (exp_regw) begin
            check({t, "_regwrite_cycle"}, 32'(regw_cyc), 32'(ret));
            check({t, "_reg_dst"}, 32'(regw_dst), 32'((k == K_R) || (k == K_MUL)));
            check({t, "_mem_to_reg"}, 32'(regw_m2r), 32'(k == K_LD));
        end
        check({t, "_mul_start_count"}, 32'(n_mul), 32'(k == K_MUL));
        if (k == K_MUL) check({t, "_mul_start_cycle"}, 32'(mul_cyc), 32'(fi + 3));
        check({t, "_pc_write_count"}, 32'(n_pcw), 32'(exp_pcw));
        check({t, "_ir_write_count"}, 32'(n_irw), 32'd1);
        check({t, "_dmem_req_count"}, 32'(n_dmreq), is_mem ? 32'(dm + 1) : 32'd0);
        check({t, "_dmem_we_count"}, 32'(n_dmwe), (k == K_ST) ? 32'(dm + 1) : 32'd0);
        if (is_mem) begin
            check({t, "_mem_size"}, 32'(size_seen), 32'(exp_size));
            check({t, "_mem_unsigned"}, 32'(uns_seen), 32'(op[2]));
        end
        check({t, "_imem_req_quiet"}, 32'(n_imreq_late), 32'd0);
        check({t, "_illegal_cycles"}, 32'(n_illeg), trap ? 32'(w - fi - 2) : 32'd0);
    endtask

    task automatic reset_in_store();
        obs_t o;
        obs_t e;
        int   n_regw;
        n_regw = 0;
        do_reset(0);
        for (int c = 1; c <= 5; c++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 6'h2b);
            o = pick(0);
            if (o.reg_write) n_regw++;
        end
        check("memwr_before_reset", {30'd0, o.dmem_req, o.dmem_we}, 32'b11);
        step(1'b1, 1'b1, 1'b0, 1'b0, 6'h2b);
        o = pick(0);
        if (o.reg_write) n_regw++;
        check("memwr_reset_outputs_zero", {12'd0, o}, 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 6'h2b);
        o = pick(0);
        if (o.reg_write) n_regw++;
        check("memwr_reset_next_dmem", {30'd0, o.dmem_req, o.dmem_we}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 6'h2b);
        o = pick(0);
        if (o.reg_write) n_regw++;
        e = '0;
        e.imem_req  = 1'b1;
        e.alu_src_b = 2'b01;
        check("memwr_reset_fetch_resumes", {12'd0, o}, {12'd0, e});
        check("memwr_reset_no_regwrite", 32'(n_regw), 32'd0);
    endtask

    initial begin
        logic [5:0] optab [15];
        logic [5:0] op;
        int         idx;
        optab = '{6'h00, 6'h1c, 6'h08, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
                  6'h28, 6'h29, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h3f};

        run_instr(0, 6'h23, 2, 1, 1'b0);
        run_instr(0, 6'h1c, 0, 0, 1'b0);
        run_instr(1, 6'h1c, 0, 0, 1'b0);
        run_instr(2, 6'h1c, 1, 0, 1'b0);
        run_instr(0, 6'h04, 0, 0, 1'b1);
        run_instr(0, 6'h04, 0, 0, 1'b0);
        run_instr(0, 6'h05, 0, 0, 1'b1);
        run_instr(0, 6'h05, 0, 0, 1'b0);
        run_instr(0, 6'h24, 1, 2, 1'b0);
        run_instr(0, 6'h21, 0, 0, 1'b0);
        run_instr(0, 6'h2b, 0, 1, 1'b0);
        run_instr(0, 6'h00, 0, 0, 1'b0);
        run_instr(0, 6'h08, 3, 0, 1'b0);
        run_instr(0, 6'h02, 1, 0, 1'b0);
        run_instr(0, 6'h3f, 0, 0, 1'b0);
        run_instr(2, 6'h3f, 0, 0, 1'b0);
        reset_in_store();

        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(0, 15);
            op  = (idx == 15) ? 6'($urandom) : optab[idx];
            run_instr($urandom_range(0, 2), op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
